opm_write_sequencer: RTL and testbench

//  Buffers host register writes (address/data pairs for the jt51 core) in a small FIFO.

---
 rtl/opm_write_sequencer.sv | 145 ++++++++++++++
 tb/tb_opm_write_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opm_write_sequencer.sv
// Write sequencer between host write capture and the jt51 core.
// Queues address/data writes in a FIFO and replays each as a cen_p1-aligned
// cs_n/wr_n strobe, then waits out the YM2151 busy time before the next one.
module opm_write_sequencer #(
  parameter int DEPTH      = 16,
  parameter int STROBE_CYC = 2,
  parameter int BUSY_CYC   = 64,
  parameter int ADDR_GAP   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cen_p1,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_a0,
  input  logic [7:0]               in_din,
  output logic                     opm_cs_n,
  output logic                     opm_wr_n,
  output logic                     opm_a0,
  output logic [7:0]               opm_din,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MAX01 = (STROBE_CYC > BUSY_CYC) ? STROBE_CYC : BUSY_CYC;
  localparam int MAXC  = (MAX01 > ADDR_GAP) ? MAX01 : ADDR_GAP;
  localparam int CW    = $clog2(MAXC + 1);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT
  } state_t;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic [8:0]    head;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cs_n_d, wr_n_d, a0_d;
  logic [7:0]    din_d;

  assign in_ready = (count != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign level    = count;
  assign busy     = (count != '0) || (state_q != IDLE);

  // FIFO storage: entries need no reset because count gates their visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a0, in_din};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a new overflow beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)                         overflow <= 1'b0;
    else if (in_valid && !in_ready)  overflow <= 1'b1;
    else if (clr_overflow)           overflow <= 1'b0;
  end

  // Sequencer state and registered jt51 bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opm_cs_n <= 1'b1;
      opm_wr_n <= 1'b1;
      opm_a0   <= 1'b0;
      opm_din  <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opm_cs_n <= cs_n_d;
      opm_wr_n <= wr_n_d;
      opm_a0   <= a0_d;
      opm_din  <= din_d;
    end
  end

  // Next-state logic: start on cen_p1 in IDLE, hold the strobe, then wait out the busy gap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_n_d  = opm_cs_n;
    wr_n_d  = opm_wr_n;
    a0_d    = opm_a0;
    din_d   = opm_din;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if ((count != '0) && cen_p1) begin
          state_d = STROBE;
          a0_d    = head[8];
          din_d   = head[7:0];
          cs_n_d  = 1'b0;
          wr_n_d  = 1'b0;
          cnt_d   = CW'(STROBE_CYC - 1);
        end
      end
      STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          cs_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          pop     = 1'b1;
          cnt_d   = opm_a0 ? CW'(BUSY_CYC - 1) : CW'(ADDR_GAP - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_opm_write_sequencer.sv
// Self-checking bench for opm_write_sequencer: a bus monitor records every
// strobe, and directed tests compare the records against hand-filled tables.
module tb_opm_write_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cen_p1;
  logic       in_valid;
  logic       in_ready;
  logic       in_a0;
  logic [7:0] in_din;
  logic       opm_cs_n;
  logic       opm_wr_n;
  logic       opm_a0;
  logic [7:0] opm_din;
  logic       busy;
  logic [4:0] level;
  logic       overflow;
  logic       clr_overflow;

  opm_write_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cen_p1       (cen_p1),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a0        (in_a0),
    .in_din       (in_din),
    .opm_cs_n     (opm_cs_n),
    .opm_wr_n     (opm_wr_n),
    .opm_a0       (opm_a0),
    .opm_din      (opm_din),
    .busy         (busy),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a0;
    logic [7:0] din;
    int         fall;
    int         rise;
    bit         cen_ok;
    bit         stable;
  } rec_t;

  typedef struct {
    logic       a0;
    logic [7:0] din;
    int         min_gap;
  } vec_t;

  rec_t recs [64];
  int   n_recs = 0;
  vec_t tbl [32];
  int   n_tbl = 0;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   cen_mode = 0;
  int   cs_wr_split = 0;
  logic prev_wr = 1'b1;
  logic cen_at_edge;

  // cen_p1 pattern generator: 0 always high, 1 toggling, 2 every 4th cycle, 3 low
  initial begin
    cen_p1 = 1'b1;
    forever begin
      @(negedge clk);
      case (cen_mode)
        0:       cen_p1 = 1'b1;
        1:       cen_p1 = ~cen_p1;
        2:       cen_p1 = (cyc % 4 == 0);
        default: cen_p1 = 1'b0;
      endcase
    end
  end

  // Bus monitor: logs each strobe with its timing, the cen_p1 that launched it and stability
  always @(posedge clk) begin
    cyc = cyc + 1;
    cen_at_edge = cen_p1;
    #1;
    if (opm_cs_n !== opm_wr_n) cs_wr_split = cs_wr_split + 1;
    if (prev_wr && !opm_wr_n) begin
      if (n_recs < 64) begin
        recs[n_recs].a0     = opm_a0;
        recs[n_recs].din    = opm_din;
        recs[n_recs].fall   = cyc;
        recs[n_recs].rise   = -1;
        recs[n_recs].cen_ok = (cen_at_edge === 1'b1);
        recs[n_recs].stable = 1'b1;
        n_recs = n_recs + 1;
      end
    end else if (!opm_wr_n && n_recs > 0) begin
      if (recs[n_recs-1].a0 !== opm_a0 || recs[n_recs-1].din !== opm_din)
        recs[n_recs-1].stable = 1'b0;
    end else if (!prev_wr && opm_wr_n && n_recs > 0) begin
      recs[n_recs-1].rise = cyc;
    end
    prev_wr = opm_wr_n;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    n_checks = n_checks + 1;
    if (act < lo || act > hi) begin
      n_fail = n_fail + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Drive one cycle of host inputs at the falling edge and return just after the rising edge
  task automatic applyStimulus(input logic v, input logic a0, input logic [7:0] din,
                               input logic clr);
    @(negedge clk);
    in_valid     = v;
    in_a0        = a0;
    in_din       = din;
    clr_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  // Wait for busy to drop within a cycle budget; returns the cycle it was first seen low
  task automatic waitIdle(input string name, input int limit, output int idle_cyc);
    idle_cyc = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        idle_cyc = cyc;
        break;
      end
    end
    checkOutput({name, " busy after drain"}, {31'd0, busy}, 32'd0);
  endtask

  // Compare logged strobes against the expectation table
  task automatic checkReplay(input string name, input bit exact);
    checkOutput({name, " strobe count"}, n_recs, n_tbl);
    for (int i = 0; i < n_tbl && i < n_recs; i++) begin
      checkOutput($sformatf("%s[%0d] a0", name, i), {31'd0, recs[i].a0}, {31'd0, tbl[i].a0});
      checkOutput($sformatf("%s[%0d] din", name, i), {24'd0, recs[i].din}, {24'd0, tbl[i].din});
      checkOutput($sformatf("%s[%0d] low time", name, i), recs[i].rise - recs[i].fall, 2);
      checkOutput($sformatf("%s[%0d] cen aligned", name, i), {31'd0, recs[i].cen_ok}, 32'd1);
      checkOutput($sformatf("%s[%0d] stable", name, i), {31'd0, recs[i].stable}, 32'd1);
      if (i > 0)
        checkRange($sformatf("%s[%0d] gap", name, i), recs[i].fall - recs[i-1].rise,
                   tbl[i].min_gap, exact ? tbl[i].min_gap : 1000);
    end
    checkOutput({name, " cs_n/wr_n split"}, cs_wr_split, 0);
  endtask

  initial begin
    int idle_cyc;
    int push_edge;

    rst = 1'b1;
    in_valid = 1'b0;
    in_a0 = 1'b0;
    in_din = 8'h00;
    clr_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset cs_n", {31'd0, opm_cs_n}, 32'd1);
    checkOutput("reset wr_n", {31'd0, opm_wr_n}, 32'd1);
    checkOutput("reset a0", {31'd0, opm_a0}, 32'd0);
    checkOutput("reset din", {24'd0, opm_din}, 32'd0);
    checkOutput("reset overflow", {31'd0, overflow}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset level", {27'd0, level}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // T6: single push into an idle empty FIFO, strobe falls on the next edge after the push edge
    $display("[TB] T6 empty-push timing");
    cen_mode = 0;
    n_recs = 0;
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0);
    push_edge = cyc;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    waitIdle("T6", 200, idle_cyc);
    checkOutput("T6 strobe count", n_recs, 1);
    checkOutput("T6 fall cycle", recs[0].fall, push_edge + 1);
    checkOutput("T6 a0 held", {31'd0, opm_a0}, 32'd1);
    checkOutput("T6 din held", {24'd0, opm_din}, 32'h5A);

    // T2: address then data with cen_p1 toggling
    $display("[TB] T2 address then data");
    cen_mode = 1;
    n_recs = 0;
    n_tbl = 2;
    tbl[0] = '{a0: 1'b0, din: 8'h20, min_gap: 0};
    tbl[1] = '{a0: 1'b1, din: 8'hC7, min_gap: 3};
    applyStimulus(1'b1, 1'b0, 8'h20, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hC7, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    waitIdle("T2", 300, idle_cyc);
    checkReplay("T2", 1'b0);

    // T3: three data writes, exact busy spacing with cen_p1 always high
    $display("[TB] T3 busy spacing");
    cen_mode = 0;
    @(negedge clk);
    n_recs = 0;
    n_tbl = 3;
    tbl[0] = '{a0: 1'b1, din: 8'hC0, min_gap: 0};
    tbl[1] = '{a0: 1'b1, din: 8'hC1, min_gap: 65};
    tbl[2] = '{a0: 1'b1, din: 8'hC2, min_gap: 65};
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    waitIdle("T3", 400, idle_cyc);
    checkReplay("T3", 1'b1);
    checkOutput("T3 busy end cycle", idle_cyc, recs[2].rise + 64);

    // T4: cen_p1 only every 4th cycle, every strobe must launch from a cen_p1 sample
    $display("[TB] T4 cen_p1 alignment");
    cen_mode = 2;
    n_recs = 0;
    n_tbl = 4;
    tbl[0] = '{a0: 1'b0, din: 8'h08, min_gap: 0};
    tbl[1] = '{a0: 1'b1, din: 8'h00, min_gap: 3};
    tbl[2] = '{a0: 1'b0, din: 8'h28, min_gap: 65};
    tbl[3] = '{a0: 1'b1, din: 8'h7F, min_gap: 3};
    for (int i = 0; i < n_tbl; i++) applyStimulus(1'b1, tbl[i].a0, tbl[i].din, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    waitIdle("T4", 600, idle_cyc);
    checkReplay("T4", 1'b0);

    // T5: fill with cen_p1 held low, overflow on the 17th push, then replay all 16 in order
    $display("[TB] T5 full and overflow");
    cen_mode = 3;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    n_recs = 0;
    n_tbl = 16;
    for (int i = 0; i < 16; i++) begin
      tbl[i].a0 = (i % 2 == 1);
      tbl[i].din = 8'h30 + 8'(i);
      tbl[i].min_gap = (i == 0) ? 0 : ((i % 2 == 0) ? 65 : 3);
    end
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, tbl[i].a0, tbl[i].din, 1'b0);
    checkOutput("T5 level full", {27'd0, level}, 32'd16);
    checkOutput("T5 in_ready full", {31'd0, in_ready}, 32'd0);
    checkOutput("T5 overflow before", {31'd0, overflow}, 32'd0);
    applyStimulus(1'b1, 1'b1, 8'hFF, 1'b0);
    checkOutput("T5 overflow set", {31'd0, overflow}, 32'd1);
    checkOutput("T5 level held", {27'd0, level}, 32'd16);
    applyStimulus(1'b1, 1'b0, 8'hEE, 1'b1);
    checkOutput("T5 set beats clear", {31'd0, overflow}, 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("T5 overflow cleared", {31'd0, overflow}, 32'd0);
    checkOutput("T5 no strobe while cen low", n_recs, 0);
    checkOutput("T5 busy while queued", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    cen_mode = 0;
    waitIdle("T5", 3000, idle_cyc);
    checkReplay("T5", 1'b1);
    checkOutput("T5 level drained", {27'd0, level}, 32'd0);

    // T1: reset in the middle of a strobe drops the in-flight and queued writes
    $display("[TB] T1 reset mid-strobe");
    cen_mode = 0;
    n_recs = 0;
    applyStimulus(1'b1, 1'b1, 8'hA1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hA2, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hA3, 1'b0);
    checkOutput("T1 strobe active", {31'd0, opm_wr_n}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("T1 wr_n after reset", {31'd0, opm_wr_n}, 32'd1);
    checkOutput("T1 cs_n after reset", {31'd0, opm_cs_n}, 32'd1);
    checkOutput("T1 level after reset", {27'd0, level}, 32'd0);
    checkOutput("T1 busy after reset", {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("T1 no further strobes", n_recs, 1);
    checkOutput("T1 wr_n idle", {31'd0, opm_wr_n}, 32'd1);
    checkOutput("T1 busy idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
